// File: rtl/ysyx_2022040010_icache_refill_pkg.sv
// Shared constants and FSM encoding for the I-cache line refill engine.
// Holds AXI burst/size/resp codes plus the line geometry the refill path is built around.
package ysyx_2022040010_icache_refill_pkg;

  localparam int OFFSET_WIDTH = 4;
  localparam int OFFSET_W     = OFFSET_WIDTH;
  localparam int LINE_BITS    = 128;

  localparam logic [3:0] AXI_ID     = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_2022040010_icache_refill_if.sv
// AXI4 read-address and read-data channels between the refill engine and the bus bridge.
// master = refill engine (issues AR, accepts R); slave = bus bridge.
interface ysyx_2022040010_icache_refill_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_2022040010_axi_rbeat_pack.sv
// Packs AXI read beats into a cache line and accumulates burst protocol errors.
// Beat written on the accepting edge; last asserts combinationally on the final accepted beat.
module ysyx_2022040010_axi_rbeat_pack #(
  parameter int         DATA_W    = 64,
  parameter int         LINE_BITS = 128,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 fire,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic [3:0]           rid,
  output logic [LINE_BITS-1:0] line,
  output logic                 err,
  output logic                 last
);
  import ysyx_2022040010_icache_refill_pkg::*;

  localparam int BEATS = LINE_BITS / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             beat_err;

  assign at_last  = (cnt == CNT_W'(BEATS - 1));
  // rlast must coincide exactly with the final beat; either mismatch is an error
  assign beat_err = (rresp != RESP_OKAY) | (rid != AXI_ID) | (rlast != at_last);
  assign last     = fire & (at_last | rlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      err  <= 1'b0;
      line <= '0;
    end else if (clr) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (fire) begin
      line[int'(cnt)*DATA_W +: DATA_W] <= rdata;
      err                              <= err | beat_err;
      cnt                              <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_2022040010_icache_refill.sv
// I-cache miss service: one AXI INCR burst per miss, refresh strobe 4 cycles after miss at zero wait.
// AR held until arready; R accepted only in R state; optional perf counters under ICACHE_REFILL_PERF_EN.
module ysyx_2022040010_icache_refill #(
  parameter int         ADDR_W    = 64,
  parameter int         DATA_W    = 64,
  parameter int         LINE_BITS = ysyx_2022040010_icache_refill_pkg::LINE_BITS,
  parameter int         OFFSET_W  = ysyx_2022040010_icache_refill_pkg::OFFSET_W,
  parameter logic [3:0] AXI_ID    = ysyx_2022040010_icache_refill_pkg::AXI_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss,
  input  logic [ADDR_W-1:0]    miss_addr,
  input  logic                 flush,
  output logic                 refresh,
  output logic [LINE_BITS-1:0] refill_line,
  output logic                 bus_err,
  output logic                 busy,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [31:0]          perf_miss_cnt,
  output logic [31:0]          perf_stall_cyc,
`endif
  ysyx_2022040010_icache_refill_if.master axi
);
  import ysyx_2022040010_icache_refill_pkg::*;

  localparam int BEATS = LINE_BITS / DATA_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] araddr_q;
  logic              flush_q;
  logic              start;
  logic              fire;
  logic              beat_last;
  logic              err_q;
  logic              unused_offset;

  assign start         = (state == S_IDLE) & miss;
  assign fire          = axi.rvalid & axi.rready;
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      araddr_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        araddr_q <= {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        flush_q  <= 1'b0;
      end else if ((state != S_IDLE) && flush) begin
        flush_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    refresh   = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      S_IDLE: if (miss) state_nxt = S_AR;
      S_AR:   if (axi.arready) state_nxt = S_R;
      S_R:    if (beat_last) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_IDLE;
        // a bad burst is reported even if a flush also arrived
        if (err_q)         bus_err = 1'b1;
        else if (!flush_q) refresh = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign axi.arvalid = (state == S_AR);
  assign axi.rready  = (state == S_R);
  assign axi.araddr  = araddr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = SIZE_8B;
  assign axi.arburst = BURST_INCR;

  ysyx_2022040010_axi_rbeat_pack #(
    .DATA_W    (DATA_W),
    .LINE_BITS (LINE_BITS),
    .AXI_ID    (AXI_ID)
  ) u_pack (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .fire  (fire),
    .rdata (axi.rdata),
    .rresp (axi.rresp),
    .rlast (axi.rlast),
    .rid   (axi.rid),
    .line  (refill_line),
    .err   (err_q),
    .last  (beat_last)
  );

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cnt  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (start) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (busy)  perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_2022040010_icache_refill.sv
// Randomised bench for the I-cache refill engine: stimulus doubles as AXI slave, monitor scores bursts.
// Expected outcome and completion cycle of each burst come from a small arithmetic model.
module tb_ysyx_2022040010_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss;
  logic [63:0]  miss_addr;
  logic         flush;
  logic         refresh;
  logic [127:0] refill_line;
  logic         bus_err;
  logic         busy;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]  perf_miss_cnt;
  logic [31:0]  perf_stall_cyc;
`endif

  ysyx_2022040010_icache_refill_if #(.ADDR_W(64), .DATA_W(64)) axi ();

  ysyx_2022040010_icache_refill dut (
    .clk            (clk),
    .rst            (rst),
    .miss           (miss),
    .miss_addr      (miss_addr),
    .flush          (flush),
    .refresh        (refresh),
    .refill_line    (refill_line),
    .bus_err        (bus_err),
    .busy           (busy),
`ifdef ICACHE_REFILL_PERF_EN
    .perf_miss_cnt  (perf_miss_cnt),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .axi            (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  localparam int K_REFRESH = 0;
  localparam int K_ERR     = 1;
  localparam int K_NONE    = 2;
  localparam int K_ABORT   = 3;

  typedef struct {
    int           kind;
    logic [127:0] line;
    int           done_cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scores each burst when busy falls, using strobes seen while busy
  int           mon_ref = 0;
  int           mon_err = 0;
  int           mon_last_cyc = 0;
  logic         mon_prev_busy = 1'b0;
  logic [127:0] mon_line = '0;

  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      if (refresh) begin
        mon_ref++;
        mon_line = refill_line;
      end
      if (bus_err) mon_err++;
      mon_last_cyc = cyc;
    end else if (!rst) begin
      check("strobe_while_idle", {refresh, bus_err}, 2'b00);
    end
    if (mon_prev_busy && !busy) begin
      if (sbq.size() == 0) begin
        check("unexpected_burst", 1, 0);
      end else begin
        e = sbq.pop_front();
        if (e.kind == K_ABORT) begin
          check("abort_no_strobe", mon_ref + mon_err, 0);
        end else begin
          check("refresh_pulses", mon_ref, (e.kind == K_REFRESH) ? 1 : 0);
          check("bus_err_pulses", mon_err, (e.kind == K_ERR) ? 1 : 0);
          if (e.kind == K_REFRESH) check("refill_line", mon_line, e.line);
          check("done_cycle", mon_last_cyc, e.done_cyc);
        end
      end
      mon_ref = 0;
      mon_err = 0;
    end
    mon_prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_r();
    axi.rvalid = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;
    axi.rid    = 4'd0;
  endtask

  // mode: 0 ok, 1 rresp error on ebeat, 2 bad rid on ebeat, 3 rlast on beat0, 4 rlast missing on beat1
  // flush_sel: 0 none, 1 during first AR cycle, 2 with beat1
  task automatic run_txn(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                         input int ard, input int g0, input int g1,
                         input int mode, input int ebeat, input int flush_sel);
    exp_t        e;
    int          nbeats;
    logic [63:0] al;
    nbeats     = (mode == 3) ? 1 : 2;
    al         = addr & ~64'hF;
    e.kind     = (mode != 0) ? K_ERR : ((flush_sel != 0) ? K_NONE : K_REFRESH);
    e.line     = {d1, d0};
    miss       = 1'b1;
    miss_addr  = addr;
    e.done_cyc = cyc + 2 + ard + g0 + ((nbeats == 2) ? g1 : 0) + nbeats;
    sbq.push_back(e);
    n_txn++;
    step();
    miss      = 1'b0;
    miss_addr = {$urandom, $urandom};
    for (int w = 0; w <= ard; w++) begin
      check("arvalid", axi.arvalid, 1);
      check("araddr", axi.araddr, al);
      check("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {4'd0, 8'd1, 3'd3, 2'd1});
      check("rready_in_ar", axi.rready, 0);
      if (flush_sel == 1 && w == 0) flush = 1'b1;
      axi.arready = (w == ard);
      step();
      flush       = 1'b0;
      axi.arready = 1'b0;
    end
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < ((b == 0) ? g0 : g1); g++) begin
        idle_r();
        step();
      end
      axi.rvalid = 1'b1;
      axi.rdata  = (b == 0) ? d0 : d1;
      axi.rresp  = (mode == 1 && ebeat == b) ? 2'b10 : 2'b00;
      axi.rid    = (mode == 2 && ebeat == b) ? 4'h5 : 4'h0;
      axi.rlast  = (mode == 3) ? 1'b1 : ((b == 1) && (mode != 4));
      if (flush_sel == 2 && b == 1) flush = 1'b1;
      check("rready_in_r", axi.rready, 1);
      step();
      flush = 1'b0;
    end
    idle_r();
    if (mode == 3) begin
      axi.rvalid = 1'b1;
      axi.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      axi.rlast  = 1'b1;
      for (int i = 0; i < 2; i++) begin
        check("no_extra_beat", axi.rready, 0);
        step();
      end
      idle_r();
    end
    for (int i = 0; i < 10 && busy; i++) step();
    check("back_to_idle", busy, 0);
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      flush = ($urandom_range(0, 2) == 0);
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst         = 1'b1;
    miss        = 1'b0;
    miss_addr   = '0;
    flush       = 1'b0;
    axi.arready = 1'b0;
    idle_r();
    repeat (3) step();
    check("rst_strobes", {refresh, bus_err, busy}, 3'b000);
    check("rst_axi", {axi.arvalid, axi.rready}, 2'b00);
    check("rst_line", refill_line, 128'd0);
    check("rst_araddr", axi.araddr, 64'd0);
    rst = 1'b0;
    step();

    run_txn(64'h0000_0000_8000_1234, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 0, 0, 0, 0, 0);
    run_txn(64'h0000_0000_8000_1234, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 5, 0, 0, 0, 0, 0);
    run_txn(64'h0000_0000_8000_2008, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 0, 0, 1, 0, 0, 2);
    run_txn(64'h0000_0000_8000_3000, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 0, 0, 0, 1, 1, 0);
    run_txn(64'h0000_0000_8000_4004, 64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 0, 3, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int r, mode, fs;
      r    = int'($urandom_range(0, 9));
      mode = (r <= 5) ? 0 : r - 5;
      r    = int'($urandom_range(0, 5));
      fs   = (r == 4) ? 1 : ((r == 5) ? 2 : 0);
      run_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              mode, int'($urandom_range(0, 1)), fs);
    end

`ifdef ICACHE_REFILL_PERF_EN
    check("perf_miss_cnt", perf_miss_cnt, n_txn);
`endif

    // Reset while in R after the first beat
    e.kind     = K_ABORT;
    e.line     = '0;
    e.done_cyc = 0;
    sbq.push_back(e);
    miss      = 1'b1;
    miss_addr = 64'h0000_0000_8000_5550;
    step();
    miss        = 1'b0;
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 64'h0123_4567_89AB_CDEF;
    step();
    idle_r();
    rst = 1'b1;
    step();
    check("rst_mid_r_axi", {axi.arvalid, axi.rready}, 2'b00);
    check("rst_mid_r_busy", {busy, refresh, bus_err}, 3'b000);
    check("rst_mid_r_line", refill_line, 128'd0);
`ifdef ICACHE_REFILL_PERF_EN
    check("rst_perf", {perf_miss_cnt, perf_stall_cyc}, 64'd0);
`endif
    rst = 1'b0;
    repeat (4) step();
    check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_icache_refill.md
Name: ysyx_2022040010_icache_refill

Overview:
- Miss-service end of the I-cache tag interface: consumes `miss` and the fetch address from the tag array.
- Fetches the 128-bit line over an AXI4 read burst, then delivers the line to the data array.
- Pulses `refresh` for exactly one cycle so the tag array installs the tag into the LRU way.
- Sits between the I-cache (tag plus data arrays) and the AXI read-address/read-data channels of the core bus bridge.

Parameters:
- ADDR_W, 64, fetch/AXI address width
- DATA_W, 64, AXI rdata width
- LINE_BITS, 128, cache line width; BEATS = LINE_BITS/DATA_W = 2
- OFFSET_W, 4, line offset bits, zeroed in araddr
- AXI_ID, 4'd0, fixed ARID for I-fetch

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss  in  1  line miss from tag array (already gated by cache & sram_e & ~flush)
- miss_addr  in  ADDR_W  fetch address causing miss
- flush  in  1  pipeline flush; a burst in flight is drained and not installed
- refresh  out  1  one-cycle install strobe to tag and data arrays
- refill_line  out  LINE_BITS  assembled line, valid while refresh=1
- bus_err  out  1  one-cycle pulse: burst completed with error, line not installed
- busy  out  1  FSM not in IDLE
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  ADDR_W  line-aligned address
- arid  out  4  = AXI_ID
- arlen  out  8  = BEATS-1
- arsize  out  3  = 3'b011 (8 B)
- arburst  out  2  = 2'b01 (INCR)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rid  in  4  read ID

Behaviour:
- Reset values: refresh=0, bus_err=0, busy=0, arvalid=0, rready=0, refill_line=0, araddr=0; state=IDLE; beat counter=0; err flag and flush flag cleared.
- IDLE: if miss=1, latch araddr = {miss_addr[ADDR_W-1:OFFSET_W], 0}, clear beat counter and flags, go to AR. arvalid rises the following cycle.
- AR: arvalid=1 held stable with araddr until arready. On arvalid&arready go to R. No retraction, even on flush.
- R: rready=1. On each rvalid&rready:
  - write rdata into refill_line[cnt*DATA_W +: DATA_W] (beat0 = bits 63:0);
  - set the err flag if rresp!=0, rid!=AXI_ID, rlast=1 with cnt!=BEATS-1, or rlast=0 with cnt=BEATS-1;
  - cnt++.
- R exit: on the beat with cnt=BEATS-1 (or on a protocol error with rlast=1), go to DONE.
- DONE, one cycle, then IDLE:
  - if neither the err flag nor the flush flag is set: refresh=1;
  - if the err flag is set: bus_err=1, refresh=0;
  - if only the flush flag is set: both outputs stay 0.
- Flush: flush=1 in any non-IDLE state sets the flush flag. A flush in IDLE has no effect.
- Miss latency: with zero-wait AXI, miss cycle T → arvalid at T+1 → beats at T+2 and T+3 → refresh at T+4.
- miss is ignored outside IDLE. In IDLE the cycle after DONE, the tag array has been updated and miss is low; a still-high miss starts a new refill (e.g. after bus_err, retry is upstream's decision).
- rlast arriving with cnt<BEATS-1 ends the burst as an error. An extra beat after DONE is not accepted (rready=0).
- refill_line holds its value after DONE until the next burst writes it.
- rst mid-burst: the FSM returns to IDLE immediately and drops arvalid/rready. The bus bridge is reset on the same rst.
- busy is asserted in AR, R and DONE. The tag array's stallreq already covers the pipeline stall.

Optional Feature:
- Macro: ICACHE_REFILL_PERF_EN.
- Defined: adds outputs perf_miss_cnt[31:0] and perf_stall_cyc[31:0].
  - perf_miss_cnt increments on each IDLE→AR transition.
  - perf_stall_cyc increments every cycle busy=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines: state encoding (IDLE, AR, R, DONE), AXI burst/size/resp constants (BURST_INCR, SIZE_8B, RESP_OKAY), LINE_BITS, OFFSET_W, reusing the existing OFFSET_WIDTH.
- One natural sub-module: ysyx_2022040010_axi_rbeat_pack (beat counter plus line shift/pack with protocol-error detection). The FSM stays in the top module.

Test Plan:
- Basic refill: miss=1, miss_addr=0x8000_1234, zero-wait AXI, rdata beats 0x1111.., 0x2222.. → araddr=0x8000_1230, arlen=1, arsize=3, arburst=1; refresh at T+4 with refill_line={0x2222..,0x1111..}.
- AR backpressure: arready held low 5 cycles → arvalid and araddr stable throughout; refresh 5 cycles later than the zero-wait case.
- Flush mid-burst: flush pulse after the first beat → both beats accepted, refresh=0, bus_err=0, IDLE after DONE.
- Error response: rresp=2'b10 on beat1 → bus_err=1 for exactly one cycle, refresh=0.
- Early rlast: rlast=1 on beat0 → error path, bus_err pulse, no third-beat acceptance.
- Reset mid-R: rst=1 during R → next cycle arvalid=0, rready=0, busy=0, refresh=0; with ICACHE_REFILL_PERF_EN, perf counters read 0.
